// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: async FIFO write-side pointer, full/almost-full/level and overflow controller
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_overflow
);
  logic [ADDR_WIDTH:0] w_bin, bin_next, gray_next, rq1, rq2, rq2_bin, level_next;
  logic                full_next;
  always_comb begin
    // no memory write while reset is held, so the stored image stays coherent with the zeroed pointer
    w_en       = w_inc & ~w_full & ~w_rst;
    w_addr     = w_bin[ADDR_WIDTH-1:0];
    bin_next   = w_bin + {{ADDR_WIDTH{1'b0}}, w_en};
    gray_next  = (bin_next >> 1) ^ bin_next;
    rq2_bin    = '0;
    for (int k = 0; k <= ADDR_WIDTH; k++) rq2_bin[k] = ^(rq2 >> k);
    level_next = bin_next - rq2_bin;
    full_next  = gray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
  end
  always_ff @(posedge w_clk)
    if (w_rst) begin
      w_bin         <= '0;
      w_ptr_gray    <= '0;
      rq1           <= '0;
      rq2           <= '0;
      w_level       <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_overflow    <= 1'b0;
    end else begin
      w_bin         <= bin_next;
      w_ptr_gray    <= gray_next;
      rq1           <= r_ptr_gray;
      rq2           <= rq1;
      w_level       <= level_next;
      w_full        <= full_next;
      w_almost_full <= level_next >= (ADDR_WIDTH+1)'(AF_THRESH);
      w_overflow    <= w_overflow | (w_inc & w_full);
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scenario tasks with an address scoreboard for fifo_wptr_full
module tb_fifo_wptr_full;
  logic       clk = 1'b0, rst, inc;
  logic [4:0] r_ptr_gray;
  logic       w_en, w_full, w_almost_full, w_overflow;
  logic [3:0] w_addr;
  logic [4:0] w_ptr_gray, w_level;
  int         n_chk = 0, n_fail = 0;
  logic [4:0] mb;
  logic [3:0] exp_q[$];
  logic [3:0] ea;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .w_clk(clk), .w_rst(rst), .w_inc(inc), .r_ptr_gray(r_ptr_gray),
    .w_en(w_en), .w_addr(w_addr), .w_ptr_gray(w_ptr_gray), .w_full(w_full),
    .w_almost_full(w_almost_full), .w_level(w_level), .w_overflow(w_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    rst = 1'b1; inc = 1'b1; r_ptr_gray = '0;
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", w_en); end
    end
    rst = 1'b0; inc = 1'b0;
    @(negedge clk);
    n_chk++; if (w_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", w_addr); end
    n_chk++; if (w_ptr_gray !== 5'd0) begin n_fail++; $display("FAIL reset_gray: got %b want 0", w_ptr_gray); end
    n_chk++; if (w_full !== 1'b0 || w_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got full=%b af=%b want 0", w_full, w_almost_full); end
    n_chk++; if (w_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", w_level); end
    n_chk++; if (w_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", w_overflow); end
    mb = '0;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      inc = 1'b1;
      exp_q.push_back(mb[3:0]);
      #1;
      n_chk++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL fill_wen[%0d]: got %b want 1", i, w_en); end
      if (w_en === 1'b1) begin
        ea = exp_q.pop_front();
        n_chk++; if (w_addr !== ea) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, w_addr, ea); end
      end
      @(posedge clk); #1;
      mb++;
      n_chk++; if (w_level !== mb) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, w_level, mb); end
      n_chk++; if (w_almost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, w_almost_full, i >= 12); end
      n_chk++; if (w_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, w_full, i == 16); end
      n_chk++; if (w_ptr_gray !== gray(mb)) begin n_fail++; $display("FAIL fill_gray[%0d]: got %b want %b", i, w_ptr_gray, gray(mb)); end
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) begin
      inc = 1'b1; #1;
      n_chk++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d]: got %b want 0", i, w_en); end
      n_chk++; if (w_addr !== 4'd0) begin n_fail++; $display("FAIL ovf_addr[%0d]: got %0d want 0", i, w_addr); end
      @(posedge clk); #1;
      n_chk++; if (w_ptr_gray !== 5'b11000) begin n_fail++; $display("FAIL ovf_gray[%0d]: got %b want 11000", i, w_ptr_gray); end
      n_chk++; if (w_overflow !== 1'b1 || w_full !== 1'b1) begin n_fail++; $display("FAIL ovf_flags[%0d]: got ovf=%b full=%b want 1 1", i, w_overflow, w_full); end
    end
  endtask

  task automatic test_free;
    inc = 1'b0; r_ptr_gray = 5'b00110;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      n_chk++; if (w_full !== (e < 3)) begin n_fail++; $display("FAIL free_full[%0d]: got %b want %b", e, w_full, e < 3); end
      n_chk++; if (w_level !== ((e < 3) ? 5'd16 : 5'd12)) begin n_fail++; $display("FAIL free_level[%0d]: got %0d want %0d", e, w_level, (e < 3) ? 16 : 12); end
      n_chk++; if (w_almost_full !== 1'b1 || w_overflow !== 1'b1) begin n_fail++; $display("FAIL free_af_ovf[%0d]: got af=%b ovf=%b want 1 1", e, w_almost_full, w_overflow); end
    end
  endtask

  task automatic test_reset_midop;
    for (int i = 1; i <= 4; i++) begin
      inc = 1'b1;
      exp_q.push_back(mb[3:0]);
      #1;
      if (w_en === 1'b1) begin
        ea = exp_q.pop_front();
        n_chk++; if (w_addr !== ea) begin n_fail++; $display("FAIL refill_addr[%0d]: got %0d want %0d", i, w_addr, ea); end
      end else begin
        n_chk++; n_fail++; $display("FAIL refill_wen[%0d]: got %b want 1", i, w_en);
      end
      @(posedge clk); #1;
      mb++;
      n_chk++; if (w_level !== 5'(12 + i)) begin n_fail++; $display("FAIL refill_level[%0d]: got %0d want %0d", i, w_level, 12 + i); end
    end
    n_chk++; if (w_full !== 1'b1) begin n_fail++; $display("FAIL refill_full: got %b want 1", w_full); end
    rst = 1'b1; r_ptr_gray = '0; #1;
    n_chk++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wen: got %b want 0", w_en); end
    @(posedge clk); #1;
    n_chk++; if ({w_en, w_addr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow} !== '0) begin
      n_fail++; $display("FAIL midrst_outs: got en=%b addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
                         w_en, w_addr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow);
    end
    rst = 1'b0; mb = '0;
    exp_q.delete();
    exp_q.push_back(mb[3:0]);
    #1;
    n_chk++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL postrst_wen: got %b want 1", w_en); end
    if (w_en === 1'b1) begin
      ea = exp_q.pop_front();
      n_chk++; if (w_addr !== ea) begin n_fail++; $display("FAIL postrst_addr: got %0d want %0d", w_addr, ea); end
    end
    @(posedge clk); #1;
    mb++;
    n_chk++; if (w_ptr_gray !== 5'b00001 || w_level !== 5'd1) begin n_fail++; $display("FAIL postrst_ptr: got gray=%b lvl=%0d want 00001 1", w_ptr_gray, w_level); end
  endtask

  task automatic test_wrap;
    logic [4:0] g0;
    logic       wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      g0 = w_ptr_gray;
      inc = 1'b1;
      exp_q.push_back(mb[3:0]);
      #1;
      if (w_en === 1'b1) begin
        ea = exp_q.pop_front();
        n_chk++; if (w_addr !== ea) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, w_addr, ea); end
        if (ea == 4'd0 && mb != 5'd0) wrapped = 1'b1;
      end else begin
        n_chk++; n_fail++; $display("FAIL wrap_wen[%0d]: got %b want 1", i, w_en);
      end
      @(posedge clk); #1;
      mb++;
      n_chk++; if ($countones(w_ptr_gray ^ g0) != 1) begin n_fail++; $display("FAIL wrap_onebit[%0d]: got %b from %b want one bit change", i, w_ptr_gray, g0); end
      n_chk++; if (w_ptr_gray !== gray(mb)) begin n_fail++; $display("FAIL wrap_gray[%0d]: got %b want %b", i, w_ptr_gray, gray(mb)); end
      n_chk++; if (w_full !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d]: got %b want 0", i, w_full); end
      r_ptr_gray = g0;
    end
    inc = 1'b0;
    n_chk++; if (!wrapped) begin n_fail++; $display("FAIL wrap_seen: got 0 want 1"); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_free;
    test_reset_midop;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
